// File: rtl/alu_operand_stage_pkg.sv
// Shared opcode and ALU function constants for the operand stage and the ALU.
package alu_operand_stage_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [3:0] FN_ADD  = 4'h0;
   localparam logic [3:0] FN_SLL  = 4'h1;
   localparam logic [3:0] FN_SLT  = 4'h2;
   localparam logic [3:0] FN_SLTU = 4'h3;
   localparam logic [3:0] FN_XOR  = 4'h4;
   localparam logic [3:0] FN_SRL  = 4'h5;
   localparam logic [3:0] FN_OR   = 4'h6;
   localparam logic [3:0] FN_AND  = 4'h7;
   localparam logic [3:0] FN_SUB  = 4'h8;
   localparam logic [3:0] FN_SRA  = 4'hd;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [3:0]  fn;
      logic [4:0]  rd;
      logic        rd_we;
      logic        illegal;
   } operands_t;

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// 32x32 integer register file: two combinational read ports, one synchronous
// write port, x0 hard-wired to zero, synchronous active-low clear.
module regfile_2r1w
   import alu_operand_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rd_addr1,
   output logic [31:0] rd_data1,
   input  logic [4:0]  rd_addr2,
   output logic [31:0] rd_data2,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);

   logic [31:0] mem [32];

   // Clear on reset; writes to x0 are dropped so it always reads zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (wr_en && (wr_addr != 5'd0)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data1 = (rd_addr1 == 5'd0) ? 32'd0 : mem[rd_addr1];
   assign rd_data2 = (rd_addr2 == 5'd0) ? 32'd0 : mem[rd_addr2];

endmodule

// File: rtl/alu_operand_stage.sv
// Decode/operand stage feeding the ALU: register read with writeback bypass,
// immediate generation, fn decode and a one-entry output register.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_x,
   output logic [XLEN-1:0] out_y,
   output logic [3:0]      out_fn,
   output logic [4:0]      out_rd,
   output logic            out_rd_we,
   output logic            out_illegal,
   output logic [XLEN-1:0] out_pc,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data
);

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] rf_rs1;
   logic [31:0] rf_rs2;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic        legal;
   logic        accept;
   operands_t   dec;

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[11:7];
   assign funct3 = in_instr[14:12];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign funct7 = in_instr[31:25];

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_u = {in_instr[31:12], 12'b0};

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   regfile_2r1w u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr1 (rs1),
      .rd_data1 (rf_rs1),
      .rd_addr2 (rs2),
      .rd_data2 (rf_rs2),
      .wr_en    (wb_en),
      .wr_addr  (wb_rd),
      .wr_data  (wb_data)
   );

   // A same-cycle writeback wins over the stale register file value.
   assign rs1_val = (wb_en && (wb_rd == rs1) && (rs1 != 5'd0)) ? wb_data : rf_rs1;
   assign rs2_val = (wb_en && (wb_rd == rs2) && (rs2 != 5'd0)) ? wb_data : rf_rs2;

   // Decode opcode/funct fields into ALU operands, fn and legality.
   always_comb begin
      dec    = '0;
      legal  = 1'b0;
      dec.rd = rd;
      case (opcode)
         OPC_OP: begin
            legal  = (funct7 == F7_BASE) ||
                     ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            dec.x  = rs1_val;
            dec.y  = rs2_val;
            dec.fn = {in_instr[30], funct3};
         end
         OPC_OP_IMM: begin
            if (funct3 == 3'd1)      legal = (funct7 == F7_BASE);
            else if (funct3 == 3'd5) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            else                     legal = 1'b1;
            dec.x  = rs1_val;
            dec.y  = imm_i;
            dec.fn = {(funct3 == 3'd5) && in_instr[30], funct3};
         end
         OPC_LUI: begin
            legal  = 1'b1;
            dec.x  = 32'd0;
            dec.y  = imm_u;
            dec.fn = FN_ADD;
         end
         OPC_AUIPC: begin
            legal  = 1'b1;
            dec.x  = in_pc;
            dec.y  = imm_u;
            dec.fn = FN_ADD;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec.x  = 32'd0;
         dec.y  = 32'd0;
         dec.fn = FN_ADD;
      end
      dec.illegal = !legal;
      dec.rd_we   = legal && (rd != 5'd0);
   end

   // Output register: loads on accept, drains when the consumer takes it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_x       <= '0;
         out_y       <= '0;
         out_fn      <= FN_ADD;
         out_rd      <= '0;
         out_rd_we   <= 1'b0;
         out_illegal <= 1'b0;
         out_pc      <= RESET_PC;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_x       <= dec.x;
         out_y       <= dec.y;
         out_fn      <= dec.fn;
         out_rd      <= dec.rd;
         out_rd_we   <= dec.rd_we;
         out_illegal <= dec.illegal;
         out_pc      <= in_pc;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vector table, hand
// sequences for hold/bypass/reset, and a randomized run against a model.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_x;
   logic [31:0] out_y;
   logic [3:0]  out_fn;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic        out_illegal;
   logic [31:0] out_pc;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_operand_stage #(.XLEN(32), .RESET_PC(32'd0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_fn      (out_fn),
      .out_rd      (out_rd),
      .out_rd_we   (out_rd_we),
      .out_illegal (out_illegal),
      .out_pc      (out_pc),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] x;
      logic [31:0] y;
      logic [3:0]  fn;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } vec_t;

   logic [31:0] regs [32];

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3,
                                         input logic [4:0] d);
      return {f7, r2, r1, f3, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] d,
                                         input logic [6:0] op);
      return {imm, r1, f3, d, op};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] d,
                                         input logic [6:0] op);
      return {imm, d, op};
   endfunction

   // Reference: what the ALU should be asked to do for an instruction, given operand values.
   function automatic vec_t ref_op(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
      vec_t r;
      int unsigned op, f3, f7, d;
      int signed   simm;
      bit          ok;
      op = instr & 32'h7f;
      d  = (instr >> 7) & 32'h1f;
      f3 = (instr >> 12) & 32'h7;
      f7 = instr >> 25;
      simm = $signed(instr) >>> 20;
      ok = 0;
      r.instr = instr; r.pc = pc; r.rd = d[4:0];
      r.x = 0; r.y = 0; r.fn = 0;
      if (op == 'h33) begin
         ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
         r.x = a; r.y = b;
         if (f7 == 'h20) r.fn = (f3 == 0) ? 4'd8 : 4'd13;
         else            r.fn = f3[3:0];
      end else if (op == 'h13) begin
         if (f3 == 1)      ok = (f7 == 0);
         else if (f3 == 5) ok = (f7 == 0) || (f7 == 'h20);
         else              ok = 1;
         r.x = a; r.y = simm;
         r.fn = (f3 == 5 && f7 == 'h20) ? 4'd13 : f3[3:0];
      end else if (op == 'h37) begin
         ok = 1; r.x = 0; r.y = instr & 32'hffff_f000;
      end else if (op == 'h17) begin
         ok = 1; r.x = pc; r.y = instr & 32'hffff_f000;
      end
      if (!ok) begin r.x = 0; r.y = 0; r.fn = 0; end
      r.ill = !ok;
      r.we  = ok && (d != 0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_ops(input string tag, input vec_t e);
      chk({tag, " valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " x"}, out_x, e.x);
      chk({tag, " y"}, out_y, e.y);
      chk({tag, " fn"}, {28'd0, out_fn}, {28'd0, e.fn});
      chk({tag, " illegal"}, {31'd0, out_illegal}, {31'd0, e.ill});
      chk({tag, " rd_we"}, {31'd0, out_rd_we}, {31'd0, e.we});
      chk({tag, " pc"}, out_pc, e.pc);
      if (!e.ill) chk({tag, " rd"}, {27'd0, out_rd}, {27'd0, e.rd});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
      in_valid = 1'b0;
      wb_en = 1'b1; wb_rd = r; wb_data = d;
      tick();
      wb_en = 1'b0;
      if (r != 0) regs[r] = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
   endtask

   vec_t vecs [10];
   vec_t ea, eb, cur;
   logic cur_valid;
   logic [31:0] ins, a, b;
   logic [4:0]  r1, r2;
   logic        acc, exp_rdy;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
      out_ready = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

      // Directed table. y for SRAI carries the full I-immediate (bit 10 set);
      // the ALU only consumes the low shift bits.
      vecs[0] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h40, 32'd5, 32'd3, 4'h0, 5'd3, 1'b1, 1'b0};
      vecs[1] = '{enc_i(12'h402, 5'd1, 3'd5, 5'd4, 7'h13), 32'h44, 32'd5, 32'h402, 4'hd, 5'd4, 1'b1, 1'b0};
      vecs[2] = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5), 32'h48, 32'd5, 32'd3, 4'h8, 5'd5, 1'b1, 1'b0};
      vecs[3] = '{enc_i(12'hfff, 5'd0, 3'd0, 5'd6, 7'h13), 32'h4c, 32'd0, 32'hffff_ffff, 4'h0, 5'd6, 1'b1, 1'b0};
      vecs[4] = '{enc_u(20'h12345, 5'd7, 7'h37), 32'h50, 32'd0, 32'h1234_5000, 4'h0, 5'd7, 1'b1, 1'b0};
      vecs[5] = '{enc_u(20'h00001, 5'd9, 7'h17), 32'h100, 32'h100, 32'h1000, 4'h0, 5'd9, 1'b1, 1'b0};
      vecs[6] = '{enc_i(12'h004, 5'd1, 3'd2, 5'd10, 7'h03), 32'h58, 32'd0, 32'd0, 4'h0, 5'd10, 1'b0, 1'b1};
      vecs[7] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'h5c, 32'd5, 32'd3, 4'h0, 5'd0, 1'b0, 1'b0};
      vecs[8] = '{enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd11), 32'h60, 32'd0, 32'd0, 4'h0, 5'd11, 1'b0, 1'b1};
      vecs[9] = '{enc_i(12'h401, 5'd1, 3'd1, 5'd12, 7'h13), 32'h64, 32'd0, 32'd0, 4'h0, 5'd12, 1'b0, 1'b1};

      do_reset();
      chk("reset valid", {31'd0, out_valid}, 32'd0);
      chk("reset x", out_x, 32'd0);
      chk("reset y", out_y, 32'd0);
      chk("reset pc", out_pc, 32'd0);
      chk("reset fn", {28'd0, out_fn}, 32'd0);
      chk("reset rd", {27'd0, out_rd}, 32'd0);
      chk("reset rd_we", {31'd0, out_rd_we}, 32'd0);
      chk("reset illegal", {31'd0, out_illegal}, 32'd0);
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);

      wb_write(5'd1, 32'd5);
      wb_write(5'd2, 32'd3);

      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
         tick();
         check_ops($sformatf("vec%0d", i), vecs[i]);
      end
      in_valid = 1'b0;
      tick();
      chk("drain valid", {31'd0, out_valid}, 32'd0);
      chk("drain keeps x", out_x, 32'd0);

      // Backpressure: hold for 3 cycles while a writeback hits a held source.
      ea = vecs[0];
      in_valid = 1'b1; in_instr = ea.instr; in_pc = ea.pc;
      tick();
      check_ops("hold load", ea);
      out_ready = 1'b0;
      in_instr = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5); in_pc = 32'h200;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("hold%0d in_ready", i), {31'd0, in_ready}, 32'd0);
         wb_en = (i == 0); wb_rd = 5'd2; wb_data = 32'h77;
         tick();
         wb_en = 1'b0;
         check_ops($sformatf("hold%0d", i), ea);
      end
      regs[2] = 32'h77;
      out_ready = 1'b1;
      #1;
      chk("release in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      eb = ref_op(in_instr, 32'h200, regs[1], regs[2]);
      check_ops("release", eb);
      in_valid = 1'b0;
      tick();
      chk("post-release valid", {31'd0, out_valid}, 32'd0);
      chk("post-release keeps y", out_y, 32'h77);

      // Same-cycle writeback bypass.
      in_valid = 1'b1; in_instr = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd8); in_pc = 32'h300;
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hAA;
      tick();
      regs[1] = 32'hAA;
      chk("bypass x", out_x, 32'hAA);
      chk("bypass y", out_y, 32'hAA);
      in_instr = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8);
      wb_rd = 5'd0; wb_data = 32'h55;
      tick();
      wb_en = 1'b0;
      chk("x0 bypass x", out_x, 32'd0);
      chk("x0 bypass y", out_y, 32'd0);
      in_instr = enc_r(7'h00, 5'd0, 5'd1, 3'd6, 5'd8);
      tick();
      chk("x1 written x", out_x, 32'hAA);
      chk("x0 write ignored y", out_y, 32'd0);

      // Reset while an op is held.
      out_ready = 1'b0;
      tick();
      chk("pre-reset valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      chk("mid reset valid", {31'd0, out_valid}, 32'd0);
      chk("mid reset x", out_x, 32'd0);
      out_ready = 1'b1;
      in_instr = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd8);
      tick();
      chk("regs cleared x", out_x, 32'd0);
      in_valid = 1'b0;
      tick();

      // Randomized traffic against the model.
      cur_valid = 1'b0;
      cur = vecs[0];
      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         case ($urandom_range(0, 2))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            default: ;
         endcase
         case ($urandom_range(0, 4))
            0: ins[6:0] = 7'h33;
            1: ins[6:0] = 7'h13;
            2: ins[6:0] = 7'h37;
            3: ins[6:0] = 7'h17;
            default: ins[6:0] = 7'h03;
         endcase
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         in_instr  = ins;
         in_pc     = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         wb_en     = ($urandom_range(0, 1) != 0);
         wb_rd     = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         #1;
         exp_rdy = !cur_valid || out_ready;
         chk("rand in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         acc = in_valid && exp_rdy;
         r1 = ins[19:15];
         r2 = ins[24:20];
         a = regs[r1];
         b = regs[r2];
         if (wb_en && wb_rd == r1 && r1 != 0) a = wb_data;
         if (wb_en && wb_rd == r2 && r2 != 0) b = wb_data;
         if (acc) begin
            cur = ref_op(ins, in_pc, a, b);
            cur_valid = 1'b1;
         end else if (out_ready) begin
            cur_valid = 1'b0;
         end
         if (wb_en && wb_rd != 0) regs[wb_rd] = wb_data;
         tick();
         if (cur_valid) check_ops("rand", cur);
         else chk("rand valid", {31'd0, out_valid}, 32'd0);
      end
      wb_en = 1'b0;
      in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
